alu_issue_decoder: RTL
======================

ALU_ISSUE_DECODER -- requirements
Module: alu_issue_decoder

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 instr_valid  in  1  instruction word offered.
REQ-005 instr  in  32  RV32I instruction word.
REQ-006 instr_ready  out  1  decoder can accept an instruction.
REQ-007 rs1_addr, rs2_addr  out  5 each  register-file read addresses.
REQ-008 rs1_data, rs2_data  in  32 each  register-file read data, valid one cycle after the address.
REQ-009 operator  out  4  ALU opcode: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SRA 0101, SRL 0110, SLL 0111, LTS 1000, LTU 1001, GES 1010, GEU 1011, EQ 1100, NE 1101.
REQ-010 left, right  out  32 each  ALU operands.
REQ-011 op_valid  out  1 / op_ready  in  1  issue handshake; transfer when both are high.
REQ-012 branch_op  out  1  issued op is a branch compare (ALU comparison output is consumed).
REQ-013 illegal  out  1  one-cycle pulse on an unsupported instruction.

Function
REQ-014 FSM states: IDLE, READ, ISSUE; instr_ready = 1 only in IDLE.
REQ-015 IDLE with instr_valid: decode instr, register rs1_addr = instr[19:15], rs2_addr = instr[24:20], operator, immediate and branch_op; go to READ. Illegal instructions are handled per REQ-020 instead.
REQ-016 READ: capture rs1_data into left; capture rs2_data (R/B-type) or the immediate (I-type) into right; go to ISSUE.
REQ-017 ISSUE: op_valid = 1; operator, left, right and branch_op held stable until op_ready; on transfer return to IDLE.
- Accept at edge N gives op_valid from cycle N+2.
- Minimum spacing between accepted instructions is 3 cycles.
REQ-018 Decode for opcode 0110011 (R-type):
- funct3 000: ADD if funct7 = 0, SUB if funct7 = 0100000.
- funct3 001 SLL, 010 LTS, 011 LTU, 100 XOR, 110 OR, 111 AND.
- funct3 101: SRL if funct7 = 0, SRA if funct7 = 0100000.
REQ-019 Decode for opcode 0010011 (I-type) and 1100011 (B-type):
- I-type uses the R-type mapping without SUB; right = sign-extended instr[31:20].
- I-type shifts: right = zero-extended instr[24:20]; instr[30] selects SRA.
- B-type funct3 000 EQ, 001 NE, 100 LTS, 101 GES, 110 LTU, 111 GEU; right = rs2 data; branch_op = 1.
REQ-020 Illegal instructions:
- Definition: any other opcode; B-type funct3 010/011; R-type funct7 not 0/0100000; 0100000 with R-type funct3 other than 000/101; I-type shift funct7 not 0 (001) or not 0/0100000 (101).
- Behaviour: illegal pulses in cycle N+1, FSM stays IDLE, no op is issued, and outputs other than illegal are unchanged.
REQ-021 instr_valid is ignored outside IDLE; the instruction is not captured.
REQ-022 op_ready high while op_valid is low has no effect.

Reset
REQ-023 rst SHALL force IDLE, op_valid 0, illegal 0, branch_op 0, operator 0000, left/right 0, rs1_addr/rs2_addr 0.
REQ-024 rst in READ or ISSUE SHALL drop the pending op without a transfer; instr_ready = 1 the cycle after rst deasserts.

Configuration
REQ-025 Macro ALU_ISSUE_ZERO_REG_EN:
- Defined: an operand sourced from register index 0 SHALL be forced to 32'h0 regardless of rs1_data/rs2_data.
- Undefined: operands SHALL pass through rs1_data/rs2_data unmodified.

Verification
REQ-026 instr 0x002081B3 (ADD), rs1_data 5, rs2_data 7 -> cycle N+2 op_valid 1, operator 0000, left 5, right 7, rs1_addr 1, rs2_addr 2, branch_op 0.
REQ-027 instr 0xFFF00093 (ADDI x1,x0,-1), rs1_data 0xDEADBEEF -> right 0xFFFFFFFF; left 0 with macro, 0xDEADBEEF without.
REQ-028 instr 0x40435293 (SRAI x5,x6,4) -> operator 0101, right 4; instr 0x0020D063 (BGE) -> operator 1010, branch_op 1.
REQ-029 op_ready low for 3 cycles in ISSUE -> outputs stable, instr_ready 0, new instr_valid ignored; op_ready high -> IDLE next cycle.
REQ-030 instr 0x00000000 -> illegal 1 for exactly cycle N+1, op_valid stays 0, instr_ready stays 1.
REQ-031 rst asserted in ISSUE -> op_valid 0 next cycle, no transfer; the following ADD issues correctly.

Source files
------------

// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder
// Decodes RV32I R-type, I-type ALU and B-type instructions into an ALU
// operation. The decoder reads the register file and issues
// {operator, left, right, branch_op} over a valid/ready handshake.
// Pipeline: IDLE (accept and decode) -> READ (capture operands) -> ISSUE (hold until op_ready).
// An unsupported instruction pulses 'illegal' for one cycle. The FSM stays in
// IDLE and every other output keeps its value.
//
// Optional feature: define ALU_ISSUE_ZERO_REG_EN to force any operand read
// from register x0 to zero, regardless of rs1_data/rs2_data.
module alu_issue_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [3:0]  operator,
  output logic [31:0] left,
  output logic [31:0] right,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        branch_op,
  output logic        illegal
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_XOR = 4'b0010,
    OP_OR  = 4'b0011,
    OP_AND = 4'b0100,
    OP_SRA = 4'b0101,
    OP_SRL = 4'b0110,
    OP_SLL = 4'b0111,
    OP_LTS = 4'b1000,
    OP_LTU = 4'b1001,
    OP_GES = 4'b1010,
    OP_GEU = 4'b1011,
    OP_EQ  = 4'b1100,
    OP_NE  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    ISSUE = 2'd2
  } state_e;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Instruction fields
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_unused_rd;

  // Combinational decode results
  alu_op_e     w_dec_op;
  logic [31:0] w_dec_imm;
  logic        w_dec_use_imm;
  logic        w_dec_branch;
  logic        w_dec_illegal;

  // FSM and control strobes
  state_e      r_state;
  state_e      w_state_next;
  logic        w_accept;
  logic        w_reject;
  logic        w_capture;

  // Registered decode / operand state
  alu_op_e     r_operator;
  logic [31:0] r_imm;
  logic        r_use_imm;
  logic        r_branch_op;
  logic [4:0]  r_rs1_addr;
  logic [4:0]  r_rs2_addr;
  logic [31:0] r_left;
  logic [31:0] r_right;
  logic        r_illegal;

  // Operand sources after optional x0 masking
  logic [31:0] w_rs1_operand;
  logic [31:0] w_rs2_operand;

  assign w_opcode    = instr[6:0];
  assign w_funct3    = instr[14:12];
  assign w_funct7    = instr[31:25];
  // The destination register is not needed to issue an ALU operation.
  assign w_unused_rd = ^instr[11:7];

  // Decode the offered instruction into operator, immediate and legality
  always_comb begin
    // NOTE: every always_comb output gets a default before the case so that
    // no path leaves it unassigned, which would infer a latch.
    w_dec_op      = OP_ADD;
    w_dec_imm     = 32'h0;
    w_dec_use_imm = 1'b0;
    w_dec_branch  = 1'b0;
    w_dec_illegal = 1'b0;

    case (w_opcode)
      OPC_R: begin
        if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            3'b000:  w_dec_op = OP_ADD;
            3'b001:  w_dec_op = OP_SLL;
            3'b010:  w_dec_op = OP_LTS;
            3'b011:  w_dec_op = OP_LTU;
            3'b100:  w_dec_op = OP_XOR;
            3'b101:  w_dec_op = OP_SRL;
            3'b110:  w_dec_op = OP_OR;
            default: w_dec_op = OP_AND;
          endcase
        end else if (w_funct7 == F7_ALT) begin
          case (w_funct3)
            3'b000:  w_dec_op = OP_SUB;
            3'b101:  w_dec_op = OP_SRA;
            default: w_dec_illegal = 1'b1;
          endcase
        end else begin
          w_dec_illegal = 1'b1;
        end
      end

      OPC_I: begin
        w_dec_use_imm = 1'b1;
        w_dec_imm     = {{20{instr[31]}}, instr[31:20]};
        case (w_funct3)
          3'b000: w_dec_op = OP_ADD;
          3'b010: w_dec_op = OP_LTS;
          3'b011: w_dec_op = OP_LTU;
          3'b100: w_dec_op = OP_XOR;
          3'b110: w_dec_op = OP_OR;
          3'b111: w_dec_op = OP_AND;
          3'b001: begin
            // Shift amount is the unsigned shamt field, not the full immediate.
            w_dec_imm = {27'h0, instr[24:20]};
            w_dec_op  = OP_SLL;
            if (w_funct7 != F7_BASE) begin
              w_dec_illegal = 1'b1;
            end
          end
          default: begin
            w_dec_imm = {27'h0, instr[24:20]};
            if (w_funct7 == F7_BASE) begin
              w_dec_op = OP_SRL;
            end else if (w_funct7 == F7_ALT) begin
              w_dec_op = OP_SRA;
            end else begin
              w_dec_illegal = 1'b1;
            end
          end
        endcase
      end

      OPC_B: begin
        w_dec_branch = 1'b1;
        case (w_funct3)
          3'b000:  w_dec_op = OP_EQ;
          3'b001:  w_dec_op = OP_NE;
          3'b100:  w_dec_op = OP_LTS;
          3'b101:  w_dec_op = OP_GES;
          3'b110:  w_dec_op = OP_LTU;
          3'b111:  w_dec_op = OP_GEU;
          default: w_dec_illegal = 1'b1;
        endcase
      end

      default: w_dec_illegal = 1'b1;
    endcase
  end

  // State register; reset abandons any in-flight operation without a transfer
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, independent of block ordering.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    w_state_next = r_state;
    instr_ready  = 1'b0;
    op_valid     = 1'b0;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_capture    = 1'b0;

    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (w_dec_illegal) begin
            w_reject = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = READ;
          end
        end
      end
      READ: begin
        w_capture    = 1'b1;
        w_state_next = ISSUE;
      end
      ISSUE: begin
        op_valid = 1'b1;
        if (op_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef ALU_ISSUE_ZERO_REG_EN
  assign w_rs1_operand = (r_rs1_addr == 5'd0) ? 32'h0 : rs1_data;
  assign w_rs2_operand = (r_rs2_addr == 5'd0) ? 32'h0 : rs2_data;
`else
  assign w_rs1_operand = rs1_data;
  assign w_rs2_operand = rs2_data;
`endif

  // Decode capture on accept, operand capture in READ, illegal pulse on reject
  always_ff @(posedge clk) begin
    // NOTE: these are a handful of datapath flops, not a memory, so all of
    // them take the reset and the outputs have a defined value after reset.
    if (rst) begin
      r_operator  <= OP_ADD;
      r_imm       <= 32'h0;
      r_use_imm   <= 1'b0;
      r_branch_op <= 1'b0;
      r_rs1_addr  <= 5'd0;
      r_rs2_addr  <= 5'd0;
      r_left      <= 32'h0;
      r_right     <= 32'h0;
      r_illegal   <= 1'b0;
    end else begin
      r_illegal <= w_reject;

      if (w_accept) begin
        r_operator  <= w_dec_op;
        r_imm       <= w_dec_imm;
        r_use_imm   <= w_dec_use_imm;
        r_branch_op <= w_dec_branch;
        r_rs1_addr  <= instr[19:15];
        r_rs2_addr  <= instr[24:20];
      end

      if (w_capture) begin
        r_left  <= w_rs1_operand;
        r_right <= r_use_imm ? r_imm : w_rs2_operand;
      end
    end
  end

  assign rs1_addr  = r_rs1_addr;
  assign rs2_addr  = r_rs2_addr;
  assign operator  = r_operator;
  assign left      = r_left;
  assign right     = r_right;
  assign branch_op = r_branch_op;
  assign illegal   = r_illegal;

endmodule
